piped_integrate_dump: RTL and testbench
=======================================

Name: piped_integrate_dump

Overview:
- Downstream consumer of the pipelined adder tree: takes the final single-sum output and its valid strobe, and accumulates a programmable number of valid samples.
- At the end of each period it dumps the total with a one-cycle strobe, then restarts from zero (integrate-and-dump).
- Sits between the adder tree and the correlator readout/bus registers.
- Saturating arithmetic, with a per-dump overflow flag.

Parameters:
- in_width, 16, width of the signed input sum (adder-tree output width).
- acc_width, 32, width of the signed accumulator and output; must be >= in_width+1.
- len_width, 16, width of the period-length control word.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- run  in  1  level enable; 0 = idle/cleared, 1 = integrate.
- acc_len  in  len_width  samples per dump period (unsigned); sampled at period start.
- in  in  in_width  signed input sample from the adder tree.
- we  in  1  input valid (the adder tree's valid).
- out  out  acc_width  signed dumped sum, held between dumps.
- valid  out  1  one-cycle strobe when out is updated.
- overflow  out  1  saturation occurred in the dumped period; updated together with out.
- busy  out  1  high while in ACCUM state.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE.
  - acc, cnt, len_q, out cleared to 0.
  - valid, overflow, busy all cleared to 0.
  - sat_flag cleared to 0.
- States:
  - IDLE: acc=0, cnt=0, sat_flag=0; inputs ignored.
    - On run=1: go to ACCUM and latch len_q = (acc_len==0 ? 1 : acc_len).
    - A we in the same cycle as the run 0->1 transition is ignored; the first sample is the next we.
  - ACCUM: each cycle with we=1, acc <= sat(acc + sign_extend(in)) and cnt <= cnt+1.
    - If the addition saturates, sat_flag <= 1.
- Dump, when we=1 and cnt==len_q-1, all at the same edge:
  - out <= sat(acc+in).
  - overflow <= sat_flag OR (this add saturated).
  - valid <= 1 (for one cycle).
  - acc <= 0, cnt <= 0, sat_flag <= 0.
  - len_q re-latched from acc_len, with the same 0->1 rule.
- Dump latency: out/valid appear 1 cycle after the edge sampling the last valid input.
- Back-to-back periods: no dead cycles; a we in the cycle after a dump is sample 0 of the next period.
- Gaps: we=0 cycles hold acc and cnt; the period length is counted in valid samples, not clock cycles.
- run=0 while in ACCUM: return to IDLE at the next edge.
  - The partial sum is discarded and no valid is produced.
  - out and overflow keep their last dumped values.
- A change to acc_len mid-period has no effect until the next period start.
- Saturation: the result is clamped to +(2^(acc_width-1)-1) or -2^(acc_width-1). acc never wraps.
- busy = (state==ACCUM), registered.
- A reset mid-period clears everything asynchronously; no valid is produced.

Decomposition:
- Shared Verilog header (piped_adder_defs): default widths, plus macros for signed max/min at a given width.
- One natural sub-module: sat_add_signed (parameter width). Combinational signed a+b, returning the saturated sum and an ovf flag. It is reused elsewhere in the dsp tree.
- The FSM, counter and output registers stay in piped_integrate_dump.

Test Plan:
1. Basic dump: acc_len=4, run=1, four we samples in = 3, -1, 5, 2 -> exactly one valid pulse one cycle after the 4th, with out=9 and overflow=0.
2. Continuous periods with gaps: acc_len=3, in=1 on every valid, we toggling 1,0,1,1,0,1,1,1.
   - Required: valid pulses after the 3rd and 6th valid samples, each with out=3.
   - No dead cycle between periods.
3. Saturation: in_width=16, acc_width=17, acc_len=4, in=32767 x4 -> out=65535 and overflow=1.
   - Next period with in=1 x4 -> out=4 and overflow=0.
4. Abort: acc_len=5, three samples of 10, then run=0 -> no valid pulse and out retains its previous value.
   - run=1 again with five samples of 2 -> out=10.
5. acc_len edge cases:
   - acc_len=0 behaves as 1: every valid sample dumps, with out=in.
   - acc_len changed from 4 to 2 mid-period: the current period still dumps after 4 samples; the following period dumps after 2.
6. Async reset: assert resetn=0 mid-period, between clock edges -> out, valid, overflow and busy go to 0 immediately.
   - After release and run=1, acc_len=2, in=7,7 -> out=14.

Source files
------------

// File: rtl/piped_integrate_dump_pkg.sv
// Shared defaults and FSM encodings for the integrate-and-dump block.
// No ports; imported by the top and its saturating adder.
package piped_integrate_dump_pkg;

    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_LEN_WIDTH = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

endpackage

// File: rtl/piped_integrate_dump_sat_add.sv
// Combinational signed adder with clamping to the signed range of width.
// Ports: a, b (signed operands), sum (clamped result), ovf (clamp happened).
module sat_add_signed
    import piped_integrate_dump_pkg::*;
#(
    parameter int width = DEF_ACC_WIDTH
) (
    input  logic signed [width-1:0] a,
    input  logic signed [width-1:0] b,
    output logic signed [width-1:0] sum,
    output logic                    ovf
);

    localparam logic signed [width-1:0] SMAX = {1'b0, {(width-1){1'b1}}};
    localparam logic signed [width-1:0] SMIN = {1'b1, {(width-1){1'b0}}};

    logic [width:0] full;

    assign full = {a[width-1], a} + {b[width-1], b};

    // The two top bits of the widened sum disagree exactly when the
    // true result does not fit; the top bit gives the true sign.
    assign ovf = full[width] ^ full[width-1];

    always_comb begin
        sum = full[width-1:0];
        if (ovf) begin
            sum = full[width] ? SMIN : SMAX;
        end
    end

endmodule

// File: rtl/piped_integrate_dump.sv
// Integrate-and-dump of the adder-tree sum over acc_len valid samples.
// Ports: clk, resetn, run, acc_len, in, we -> out, valid, overflow, busy.
module piped_integrate_dump
    import piped_integrate_dump_pkg::*;
#(
    parameter int in_width  = DEF_IN_WIDTH,
    parameter int acc_width = DEF_ACC_WIDTH,
    parameter int len_width = DEF_LEN_WIDTH
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        run,
    input  logic [len_width-1:0]        acc_len,
    input  logic signed [in_width-1:0]  in,
    input  logic                        we,
    output logic signed [acc_width-1:0] out,
    output logic                        valid,
    output logic                        overflow,
    output logic                        busy
);

    localparam logic [len_width-1:0] LEN_ONE = {{(len_width-1){1'b0}}, 1'b1};

    logic [0:0]                  state;
    logic signed [acc_width-1:0] acc;
    logic [len_width-1:0]        cnt;
    logic [len_width-1:0]        len_q;
    logic                        sat_flag;

    logic signed [acc_width-1:0] in_ext;
    logic signed [acc_width-1:0] sum;
    logic                        add_ovf;
    logic [len_width-1:0]        len_next;
    logic                        last;

    assign in_ext = {{(acc_width-in_width){in[in_width-1]}}, in};

    // A zero length would never dump; treat it as one sample per period.
    assign len_next = (acc_len == '0) ? LEN_ONE : acc_len;
    assign last = (cnt == len_q - LEN_ONE);

    sat_add_signed #(
        .width(acc_width)
    ) u_add (
        .a  (acc),
        .b  (in_ext),
        .sum(sum),
        .ovf(add_ovf)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            acc      <= '0;
            cnt      <= '0;
            len_q    <= '0;
            sat_flag <= 1'b0;
            out      <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    acc      <= '0;
                    cnt      <= '0;
                    sat_flag <= 1'b0;
                    // A we coinciding with run's rising edge is dropped.
                    if (run) begin
                        state <= ST_ACCUM;
                        busy  <= 1'b1;
                        len_q <= len_next;
                    end
                end
                ST_ACCUM: begin
                    if (!run) begin
                        // Abort: partial sum dropped, last dump kept.
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        acc      <= '0;
                        cnt      <= '0;
                        sat_flag <= 1'b0;
                    end else if (we) begin
                        if (last) begin
                            out      <= sum;
                            overflow <= sat_flag | add_ovf;
                            valid    <= 1'b1;
                            acc      <= '0;
                            cnt      <= '0;
                            sat_flag <= 1'b0;
                            len_q    <= len_next;
                        end else begin
                            acc      <= sum;
                            cnt      <= cnt + LEN_ONE;
                            sat_flag <= sat_flag | add_ovf;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piped_integrate_dump.sv
// Directed bench for piped_integrate_dump: vector table plus corner cases.
// No ports; drives inputs on negedge side, checks after each posedge.
module tb_piped_integrate_dump;

    localparam int IW = 16;
    localparam int AW = 17;
    localparam int LW = 16;

    logic                 clk;
    logic                 resetn;
    logic                 run;
    logic [LW-1:0]        acc_len;
    logic signed [IW-1:0] din;
    logic                 we;
    logic signed [AW-1:0] out;
    logic                 valid;
    logic                 overflow;
    logic                 busy;

    int checks;
    int failures;

    typedef struct {
        logic                 run;
        logic                 we;
        logic [LW-1:0]        len;
        logic signed [IW-1:0] din;
        logic                 ev;
        logic signed [AW-1:0] eout;
        logic                 eovf;
        logic                 ebusy;
    } vec_t;

    vec_t tbl[23];

    piped_integrate_dump #(
        .in_width (IW),
        .acc_width(AW),
        .len_width(LW)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .run     (run),
        .acc_len (acc_len),
        .in      (din),
        .we      (we),
        .out     (out),
        .valid   (valid),
        .overflow(overflow),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [LW-1:0] l,
                        input logic signed [IW-1:0] d);
        run = r;
        we = w;
        acc_len = l;
        din = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic ev,
                           input logic signed [AW-1:0] eo, input logic eovf,
                           input logic eb);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, ev});
        chk({tag, ".out"}, out, eo);
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, eovf});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    endtask

    initial begin
        checks = 0;
        failures = 0;

        // basic dump 3,-1,5,2 (first row's we is dropped on run edge)
        tbl[0]  = '{1, 1, 16'd4, 16'sd100, 0, 17'sd0, 0, 1};
        tbl[1]  = '{1, 1, 16'd4, 16'sd3,   0, 17'sd0, 0, 1};
        tbl[2]  = '{1, 1, 16'd4, -16'sd1,  0, 17'sd0, 0, 1};
        tbl[3]  = '{1, 1, 16'd4, 16'sd5,   0, 17'sd0, 0, 1};
        tbl[4]  = '{1, 1, 16'd3, 16'sd2,   1, 17'sd9, 0, 1};
        // len 3 with gaps: we 1,0,1,1,0,1,1,1
        tbl[5]  = '{1, 0, 16'd3, 16'sd1,   0, 17'sd9, 0, 1};
        tbl[6]  = '{1, 1, 16'd3, 16'sd1,   0, 17'sd9, 0, 1};
        tbl[7]  = '{1, 0, 16'd3, 16'sd1,   0, 17'sd9, 0, 1};
        tbl[8]  = '{1, 1, 16'd3, 16'sd1,   0, 17'sd9, 0, 1};
        tbl[9]  = '{1, 1, 16'd3, 16'sd1,   1, 17'sd3, 0, 1};
        tbl[10] = '{1, 0, 16'd3, 16'sd1,   0, 17'sd3, 0, 1};
        tbl[11] = '{1, 1, 16'd3, 16'sd1,   0, 17'sd3, 0, 1};
        tbl[12] = '{1, 1, 16'd3, 16'sd1,   0, 17'sd3, 0, 1};
        tbl[13] = '{1, 1, 16'd0, 16'sd1,   1, 17'sd3, 0, 1};
        // acc_len=0 acts as 1, back to back
        tbl[14] = '{1, 1, 16'd0, 16'sd5,   1, 17'sd5, 0, 1};
        tbl[15] = '{1, 1, 16'd4, -16'sd7,  1, -17'sd7, 0, 1};
        // acc_len 4 -> 2 mid-period
        tbl[16] = '{1, 1, 16'd2, 16'sd1,   0, -17'sd7, 0, 1};
        tbl[17] = '{1, 1, 16'd2, 16'sd1,   0, -17'sd7, 0, 1};
        tbl[18] = '{1, 1, 16'd2, 16'sd1,   0, -17'sd7, 0, 1};
        tbl[19] = '{1, 1, 16'd2, 16'sd1,   1, 17'sd4, 0, 1};
        tbl[20] = '{1, 1, 16'd2, 16'sd10,  0, 17'sd4, 0, 1};
        tbl[21] = '{1, 1, 16'd2, 16'sd10,  1, 17'sd20, 0, 1};
        tbl[22] = '{1, 0, 16'd2, 16'sd0,   0, 17'sd20, 0, 1};

        run = 1'b0;
        we = 1'b0;
        acc_len = '0;
        din = '0;
        resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0);
        resetn = 1'b1;
        step(0, 1, 16'd4, 16'sd9);
        chk_all("idle", 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            step(tbl[i].run, tbl[i].we, tbl[i].len, tbl[i].din);
            chk_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eout,
                    tbl[i].eovf, tbl[i].ebusy);
        end

        // saturation, then a clean period clears overflow
        step(0, 0, 16'd4, 16'sd0);
        chk_all("sat_idle", 0, 20, 0, 0);
        step(1, 0, 16'd4, 16'sd0);
        for (int i = 0; i < 3; i++) step(1, 1, 16'd4, 16'sd32767);
        chk_all("sat_pre", 0, 20, 0, 1);
        step(1, 1, 16'd4, 16'sd32767);
        chk_all("sat_dump", 1, 65535, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 1, 16'd5, 16'sd1);
        chk_all("sat_hold", 0, 65535, 1, 1);
        step(1, 1, 16'd5, 16'sd1);
        chk_all("post_sat", 1, 4, 0, 1);

        // abort after three samples of 10
        for (int i = 0; i < 3; i++) step(1, 1, 16'd5, 16'sd10);
        chk_all("abort_pre", 0, 4, 0, 1);
        step(0, 1, 16'd5, 16'sd10);
        chk_all("abort", 0, 4, 0, 0);
        step(0, 0, 16'd5, 16'sd0);
        chk_all("abort_idle", 0, 4, 0, 0);
        step(1, 0, 16'd5, 16'sd0);
        for (int i = 0; i < 4; i++) step(1, 1, 16'd5, 16'sd2);
        chk_all("restart_pre", 0, 4, 0, 1);
        step(1, 1, 16'd5, 16'sd2);
        chk_all("restart", 1, 10, 0, 1);

        // async reset between edges while valid is high
        #2;
        resetn = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        chk_all("rst_hold", 0, 0, 0, 0);
        resetn = 1'b1;
        step(1, 0, 16'd2, 16'sd0);
        step(1, 1, 16'd2, 16'sd7);
        chk_all("after_rst1", 0, 0, 0, 1);
        step(1, 1, 16'd2, 16'sd7);
        chk_all("after_rst2", 1, 14, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
